// File: rtl/ahb_arb_pkg.sv
// Shared types for the two-master AHB arbiter: FSM state encoding, master ids
// and a helper that maps a master id onto its grant state.
// Imported by ahb_bus_arbiter; no logic of its own.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } arb_state_e;

  // Master ids double as address/data mux select values.
  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  function automatic arb_state_e grant_state(input logic id);
    return (id == M2) ? GRANT2 : GRANT1;
  endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// Purpose: counts address beats within one grant; flags the last beat of a burst.
// Latency: count updates on the clk edge after inc/clr; term is combinational from the count.
// Backpressure: none of its own; the caller withholds inc while hready is low.
// Ports: clk, rst (async active-high), inc, clr (clr wins over inc), cnt, term (cnt == BURST_LEN-1).
module ahb_beat_counter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = $clog2(BURST_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term = (cnt == LAST);

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Purpose: two-master AHB arbiter; sequences HADDR/HWDATA load enables and address/data mux selects.
// Latency: request in IDLE -> grant 1 cycle; address beat -> data load on the next hready cycle.
// Backpressure: hready=0 freezes state, beat count, grants, muxes and data phase; no sel asserted.
// Ports: clk, rst (async active-high), hbusreq_1/2 in, hready in;
//        hgrant_1/2 (registered), sel1/sel2 address loads, sel3/sel4 data loads,
//        mux1 address select, mux2 data select, hmaster (= mux1).
// Build option: AHB_ARB_ROUND_ROBIN_EN -> ties go to the master that did not own the bus last;
//               otherwise master 1 wins ties.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic hbusreq_1,
  input  logic hbusreq_2,
  input  logic hready,
  output logic hgrant_1,
  output logic hgrant_2,
  output logic sel1,
  output logic sel2,
  output logic sel3,
  output logic sel4,
  output logic mux1,
  output logic mux2,
  output logic hmaster
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  arb_state_e       state;
  logic [CNT_W-1:0] beat_cnt;
  logic             cnt_term;
  logic             data_owner;
  logic             data_vld;

  logic beat;
  logic own_req;
  logic other_req;
  logic rearb;
  logic tie_pick;
  logic idle_pick;
  logic grant_en;
  logic grant_id;
  logic release_bus;

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic last_owner;
  assign tie_pick = ~last_owner;
`else
  assign tie_pick = M1;
`endif

  assign idle_pick = (hbusreq_1 && hbusreq_2) ? tie_pick : (hbusreq_1 ? M1 : M2);

  // Re-arbitration happens only on a beat: burst exhausted or owner dropped its request.
  always_comb begin
    beat        = (state != IDLE) && hready;
    own_req     = (state == GRANT2) ? hbusreq_2 : hbusreq_1;
    other_req   = (state == GRANT2) ? hbusreq_1 : hbusreq_2;
    rearb       = beat && (cnt_term || !own_req);
    grant_en    = 1'b0;
    grant_id    = M1;
    release_bus = 1'b0;
    case (state)
      IDLE: begin
        grant_en = hbusreq_1 || hbusreq_2;
        grant_id = idle_pick;
      end
      GRANT1, GRANT2: begin
        if (rearb) begin
          if (other_req) begin
            // The waiting master always gets the bus at the end of a burst.
            grant_en = 1'b1;
            grant_id = ~mux1;
          end else if (!own_req) begin
            release_bus = 1'b1;
          end
          // Own request still set and nobody else waiting: stay, counter restarts.
        end
      end
      default: release_bus = 1'b1;
    endcase
  end

  ahb_beat_counter #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (beat && !rearb),
    .clr  ((state == IDLE) || rearb),
    .cnt  (beat_cnt),
    .term (cnt_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hgrant_1   <= 1'b0;
      hgrant_2   <= 1'b0;
      mux1       <= M1;
      data_owner <= M1;
      data_vld   <= 1'b0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      last_owner <= M1;
`endif
    end else begin
      // Data phase trails the address phase by one hready beat.
      if (hready) begin
        data_vld <= beat;
        if (beat) begin
          data_owner <= mux1;
        end
      end
      if (grant_en) begin
        state    <= grant_state(grant_id);
        hgrant_1 <= (grant_id == M1);
        hgrant_2 <= (grant_id == M2);
        mux1     <= grant_id;
`ifdef AHB_ARB_ROUND_ROBIN_EN
        last_owner <= grant_id;
`endif
      end else if (release_bus) begin
        // mux1 keeps the last owner while idle; nothing loads without a grant.
        state    <= IDLE;
        hgrant_1 <= 1'b0;
        hgrant_2 <= 1'b0;
      end
    end
  end

  assign sel1    = hgrant_1 && hready;
  assign sel2    = hgrant_2 && hready;
  assign sel3    = data_vld && hready && (data_owner == M1);
  assign sel4    = data_vld && hready && (data_owner == M2);
  assign mux2    = data_owner;
  assign hmaster = mux1;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (BURST_LEN=4): reset mid-burst, single burst,
// handover, stall, early release and the tie policy of the selected build.
// Output vector order: {hgrant_1, hgrant_2, sel1, sel2, sel3, sel4, mux1, mux2, hmaster}.
module tb_ahb_bus_arbiter;
  import ahb_arb_pkg::*;

  logic clk;
  logic rst;
  logic hbusreq_1;
  logic hbusreq_2;
  logic hready;
  logic hgrant_1;
  logic hgrant_2;
  logic sel1;
  logic sel2;
  logic sel3;
  logic sel4;
  logic mux1;
  logic mux2;
  logic hmaster;
  logic [8:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  ahb_bus_arbiter #(.BURST_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hbusreq_1 (hbusreq_1),
    .hbusreq_2 (hbusreq_2),
    .hready    (hready),
    .hgrant_1  (hgrant_1),
    .hgrant_2  (hgrant_2),
    .sel1      (sel1),
    .sel2      (sel2),
    .sel3      (sel3),
    .sel4      (sel4),
    .mux1      (mux1),
    .mux2      (mux2),
    .hmaster   (hmaster)
  );

  assign outs = {hgrant_1, hgrant_2, sel1, sel2, sel3, sel4, mux1, mux2, hmaster};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then check the settled outputs.
  task automatic cyc(input logic r1, input logic r2, input logic hr,
                     input logic [8:0] exp, input string tag);
    @(posedge clk);
    #1;
    hbusreq_1 = r1;
    hbusreq_2 = r2;
    hready    = hr;
    #1;
    chk(tag, 32'(outs), 32'(exp));
    chk({tag, "_excl"}, 32'(hgrant_1 & hgrant_2), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    hbusreq_1 = 1'b0;
    hbusreq_2 = 1'b0;
    hready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("por_outs", 32'(outs), 32'd0);
    chk("por_state", 32'(dut.state), 32'(IDLE));

    // Reset asserted mid-burst while at beat 2
    cyc(1, 0, 1, 9'b000000000, "rb_req");
    cyc(1, 0, 1, 9'b101000000, "rb_b0");
    cyc(1, 0, 1, 9'b101010000, "rb_b1");
    cyc(1, 0, 1, 9'b101010000, "rb_b2");
    chk("rb_cnt2", 32'(dut.beat_cnt), 32'd2);
    hbusreq_1 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rb_async_outs", 32'(outs), 32'd0);
    chk("rb_async_state", 32'(dut.state), 32'(IDLE));
    chk("rb_async_cnt", 32'(dut.beat_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rb_release", 32'(outs), 32'd0);
    cyc(0, 0, 1, 9'b000000000, "rb_idle");

    // Single burst of M1: sel1 cycles 1-4, sel3 cycles 2-5
    cyc(1, 0, 1, 9'b000000000, "sb_c0");
    cyc(1, 0, 1, 9'b101000000, "sb_c1");
    cyc(1, 0, 1, 9'b101010000, "sb_c2");
    cyc(1, 0, 1, 9'b101010000, "sb_c3");
    cyc(0, 0, 1, 9'b101010000, "sb_c4");
    cyc(0, 0, 1, 9'b000010000, "sb_c5");
    cyc(0, 0, 1, 9'b000000000, "sb_c6");

    // Handover M1 -> M2 after a full burst with both requesting
    cyc(1, 0, 1, 9'b000000000, "ho_req");
    cyc(1, 1, 1, 9'b101000000, "ho_b0");
    cyc(1, 1, 1, 9'b101010000, "ho_b1");
    cyc(1, 1, 1, 9'b101010000, "ho_b2");
    cyc(1, 1, 1, 9'b101010000, "ho_b3");
    cyc(0, 1, 1, 9'b010110101, "ho_switch");
    cyc(0, 0, 1, 9'b010101111, "ho_m2data");
    cyc(0, 0, 1, 9'b000001111, "ho_tail");
    cyc(0, 0, 1, 9'b000000111, "ho_idle");

    // Stall at beat 2 for three cycles
    cyc(1, 0, 1, 9'b000000111, "st_req");
    cyc(1, 0, 1, 9'b101000010, "st_b0");
    cyc(1, 0, 1, 9'b101010000, "st_b1");
    cyc(1, 0, 0, 9'b100000000, "st_hold1");
    chk("st_cnt_h1", 32'(dut.beat_cnt), 32'd2);
    cyc(1, 0, 0, 9'b100000000, "st_hold2");
    cyc(1, 0, 0, 9'b100000000, "st_hold3");
    chk("st_cnt_h3", 32'(dut.beat_cnt), 32'd2);
    cyc(1, 0, 1, 9'b101010000, "st_b2");
    chk("st_cnt_b2", 32'(dut.beat_cnt), 32'd2);
    cyc(1, 0, 1, 9'b101010000, "st_b3");
    cyc(0, 0, 1, 9'b101010000, "st_restart");
    chk("st_cnt_restart", 32'(dut.beat_cnt), 32'd0);
    cyc(0, 0, 1, 9'b000010000, "st_tail");
    cyc(0, 0, 1, 9'b000000000, "st_idle");

    // Early release: request dropped on the second beat, nobody else waiting
    cyc(1, 0, 1, 9'b000000000, "er_req");
    cyc(1, 0, 1, 9'b101000000, "er_b0");
    cyc(0, 0, 1, 9'b101010000, "er_b1");
    cyc(0, 0, 1, 9'b000010000, "er_tail");
    chk("er_state", 32'(dut.state), 32'(IDLE));
    cyc(0, 0, 1, 9'b000000000, "er_idle");

    // Tie from IDLE with M1 as last owner
    cyc(1, 1, 1, 9'b000000000, "tie_req");
`ifdef AHB_ARB_ROUND_ROBIN_EN
    cyc(1, 1, 1, 9'b010100101, "tie_grant");
    cyc(0, 0, 1, 9'b010101111, "tie_release");
    cyc(0, 0, 1, 9'b000001111, "tie_tail");
    cyc(0, 0, 1, 9'b000000111, "tie_idle");
`else
    cyc(1, 1, 1, 9'b101000000, "tie_grant");
    cyc(0, 0, 1, 9'b101010000, "tie_release");
    cyc(0, 0, 1, 9'b000010000, "tie_tail");
    cyc(0, 0, 1, 9'b000000000, "tie_idle");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
